prio_arbiter_rr: RTL and testbench

- Parametrised, registered N-input priority arbiter. Next generation of the combinational 8-to-3 priority encoder.
- Adds runtime-selectable fixed-priority or round-robin mode, a valid/ready grant handshake, and an accepted-grant counter.
- Arbitrates N request lines into one granted index for a downstream consumer.
- Output stays stable until the consumer accepts it.

---
 rtl/prio_arbiter_rr.sv | 152 +++++++++++++++
 tb/tb_prio_arbiter_rr.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// -----------------------------------------------------------------------------
// prio_arbiter_rr
//   Registered N-input priority arbiter with runtime-selectable fixed-priority
//   or round-robin arbitration. The winner is presented on a valid/ready grant
//   handshake and held stable until the consumer accepts it. Accepted grants
//   are counted.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   req          request vector, bit i = requester i
//   mode         0 = fixed priority (highest index wins), 1 = round-robin
//   gnt_ready    consumer accepts the current grant when high with gnt_valid
//   gnt_valid    grant outputs hold a valid winner
//   gnt_idx      binary index of the winner (keeps last value when idle)
//   gnt_onehot   one-hot form of gnt_idx, all zero when gnt_valid = 0
//   grant_count  number of accepted grants, wraps at 2^CNTW
// -----------------------------------------------------------------------------
module prio_arbiter_rr #(
   parameter int N    = 8,
   parameter int IDXW = 3,
   parameter int CNTW = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic            mode,
   input  logic            gnt_ready,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx,
   output logic [N-1:0]    gnt_onehot,
   output logic [CNTW-1:0] grant_count
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_r;
   logic [IDXW-1:0] ptr_r;

   logic            accept_s;
   logic [IDXW-1:0] ptr_eff_s;
   logic [IDXW:0]   pick_s;
   logic            win_found_s;
   logic [IDXW-1:0] win_idx_s;
   logic [N-1:0]    win_onehot_s;

   // Descending, wrapping search starting at p-1 and ending at p.
   // Candidates are visited from lowest to highest priority so the last hit
   // is the winner. With p = 0 the order is N-1..0, i.e. fixed priority.
   // Returns {found, index}.
   function automatic logic [IDXW:0] pick_winner(input logic [N-1:0]    r,
                                                 input logic [IDXW-1:0] p);
      logic [IDXW:0] res;
      int            t;
      res = {(IDXW+1){1'b0}};
      for (int k = N; k >= 1; k--) begin
         t = int'(p) - k;
         if (t < 0) begin
            t = t + N;
         end
         if (r[t]) begin
            res = {1'b1, t[IDXW-1:0]};
         end
      end
      return res;
   endfunction

   // Binary index to one-hot vector.
   function automatic logic [N-1:0] to_onehot(input logic [IDXW-1:0] idx);
      logic [N-1:0] oh;
      oh      = {N{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Winner selection. On an accept in round-robin mode the pointer moves to
   // the index being retired, and the reload must already use that new value.
   always_comb begin
      accept_s = gnt_valid & gnt_ready;
      if (accept_s && mode) begin
         ptr_eff_s = gnt_idx;
      end else begin
         ptr_eff_s = ptr_r;
      end
      if (mode) begin
         pick_s = pick_winner(req, ptr_eff_s);
      end else begin
         pick_s = pick_winner(req, {IDXW{1'b0}});
      end
      win_found_s  = pick_s[IDXW];
      win_idx_s    = pick_s[IDXW-1:0];
      win_onehot_s = to_onehot(win_idx_s);
   end

   // Grant FSM, round-robin pointer and accepted-grant counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= IDLE;
         ptr_r       <= {IDXW{1'b0}};
         gnt_valid   <= 1'b0;
         gnt_idx     <= {IDXW{1'b0}};
         gnt_onehot  <= {N{1'b0}};
         grant_count <= {CNTW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (win_found_s) begin
                  gnt_idx    <= win_idx_s;
                  gnt_onehot <= win_onehot_s;
                  gnt_valid  <= 1'b1;
                  state_r    <= GRANT;
               end else begin
                  gnt_valid  <= 1'b0;
                  gnt_onehot <= {N{1'b0}};
               end
            end
            GRANT: begin
               // Outputs are sticky until accepted, whatever req/mode do.
               if (accept_s) begin
                  grant_count <= grant_count + CNTW'(1'b1);
                  if (mode) begin
                     ptr_r <= gnt_idx;
                  end else begin
                     ptr_r <= ptr_r;
                  end
                  if (win_found_s) begin
                     gnt_idx    <= win_idx_s;
                     gnt_onehot <= win_onehot_s;
                     gnt_valid  <= 1'b1;
                  end else begin
                     // gnt_idx intentionally keeps its last value.
                     gnt_onehot <= {N{1'b0}};
                     gnt_valid  <= 1'b0;
                     state_r    <= IDLE;
                  end
               end else begin
                  gnt_valid <= 1'b1;
               end
            end
            default: begin
               state_r    <= IDLE;
               gnt_valid  <= 1'b0;
               gnt_onehot <= {N{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter_rr
//   Directed test of prio_arbiter_rr (N=8). A second instance with a 4-bit
//   counter shares the stimulus so counter wrap can be observed.
// -----------------------------------------------------------------------------
module tb_prio_arbiter_rr;

   logic        clock;
   logic        reset;
   logic [7:0]  req;
   logic        mode;
   logic        gnt_ready;

   logic        gnt_valid;
   logic [2:0]  gnt_idx;
   logic [7:0]  gnt_onehot;
   logic [15:0] grant_count;

   logic        gnt_valid4;
   logic [2:0]  gnt_idx4;
   logic [7:0]  gnt_onehot4;
   logic [3:0]  grant_count4;

   int checks;
   int failures;

   prio_arbiter_rr #(.N(8), .IDXW(3), .CNTW(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .mode        (mode),
      .gnt_ready   (gnt_ready),
      .gnt_valid   (gnt_valid),
      .gnt_idx     (gnt_idx),
      .gnt_onehot  (gnt_onehot),
      .grant_count (grant_count)
   );

   prio_arbiter_rr #(.N(8), .IDXW(3), .CNTW(4)) dut4 (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .mode        (mode),
      .gnt_ready   (gnt_ready),
      .gnt_valid   (gnt_valid4),
      .gnt_idx     (gnt_idx4),
      .gnt_onehot  (gnt_onehot4),
      .grant_count (grant_count4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Check all main-instance outputs at once.
   task automatic chk_all(input string tag, input logic v, input logic [2:0] idx,
                          input logic [7:0] oh, input logic [15:0] cnt);
      chk({tag, ".valid"},  32'(gnt_valid),   32'(v));
      chk({tag, ".idx"},    32'(gnt_idx),     32'(idx));
      chk({tag, ".onehot"}, 32'(gnt_onehot),  32'(oh));
      chk({tag, ".count"},  32'(grant_count), 32'(cnt));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      req       = 8'hFF;
      mode      = 1'b0;
      gnt_ready = 1'b0;

      // Reset with all requests asserted.
      tick();
      tick();
      chk_all("reset", 1'b0, 3'd0, 8'h00, 16'd0);
      chk("reset.count4", 32'(grant_count4), 32'd0);

      // Idle with no requests.
      reset = 1'b0;
      req   = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle.valid", 32'(gnt_valid), 32'd0);
      end

      // Fixed priority: highest set bit (5) wins, back-to-back accepts.
      mode      = 1'b0;
      gnt_ready = 1'b1;
      req       = 8'b0010_1100;
      tick(); chk_all("fix0", 1'b1, 3'd5, 8'h20, 16'd0);
      tick(); chk_all("fix1", 1'b1, 3'd5, 8'h20, 16'd1);
      tick(); chk_all("fix2", 1'b1, 3'd5, 8'h20, 16'd2);
      tick(); chk_all("fix3", 1'b1, 3'd5, 8'h20, 16'd3);

      // Empty exit: accept with no requests, idx keeps last value.
      req = 8'h00;
      tick(); chk_all("exit1", 1'b0, 3'd5, 8'h00, 16'd4);

      // Round-robin over bits 7,4,1 starting from P=0.
      mode = 1'b1;
      req  = 8'b1001_0010;
      tick(); chk_all("rr0", 1'b1, 3'd7, 8'h80, 16'd4);
      tick(); chk_all("rr1", 1'b1, 3'd4, 8'h10, 16'd5);
      tick(); chk_all("rr2", 1'b1, 3'd1, 8'h02, 16'd6);
      tick(); chk_all("rr3", 1'b1, 3'd7, 8'h80, 16'd7);
      tick(); chk_all("rr4", 1'b1, 3'd4, 8'h10, 16'd8);
      tick(); chk_all("rr5", 1'b1, 3'd1, 8'h02, 16'd9);

      // Backpressure: grant 1 held, P=4; then accept walks 0,7,6.
      req       = 8'hFF;
      gnt_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_all("bp_hold", 1'b1, 3'd1, 8'h02, 16'd9);
      end
      gnt_ready = 1'b1;
      tick(); chk_all("bp_acc0", 1'b1, 3'd0, 8'h01, 16'd10);
      tick(); chk_all("bp_acc1", 1'b1, 3'd7, 8'h80, 16'd11);
      tick(); chk_all("bp_acc2", 1'b1, 3'd6, 8'h40, 16'd12);

      // Sticky grant: idx 3 held after its request drops and mode changes.
      req = 8'b0000_1000;
      tick(); chk_all("sticky0", 1'b1, 3'd3, 8'h08, 16'd13);
      req       = 8'h00;
      gnt_ready = 1'b0;
      tick(); chk_all("sticky1", 1'b1, 3'd3, 8'h08, 16'd13);
      mode = 1'b0;
      tick(); chk_all("sticky2", 1'b1, 3'd3, 8'h08, 16'd13);
      mode      = 1'b1;
      gnt_ready = 1'b1;
      tick(); chk_all("sticky_exit", 1'b0, 3'd3, 8'h00, 16'd14);
      // Ready while idle does nothing.
      tick(); chk_all("ready_idle", 1'b0, 3'd3, 8'h00, 16'd14);

      // Counter wrap on the 4-bit instance (16 accepts -> 0).
      mode = 1'b0;
      req  = 8'b0000_0001;
      tick(); chk_all("wrap0", 1'b1, 3'd0, 8'h01, 16'd14);
      tick(); chk("wrap1.count4", 32'(grant_count4), 32'd15);
      tick(); chk("wrap2.count4", 32'(grant_count4), 32'd0);
      chk("wrap2.count", 32'(grant_count), 32'd16);
      req = 8'h00;
      tick(); chk("wrap3.count4", 32'(grant_count4), 32'd1);
      chk_all("wrap3", 1'b0, 3'd0, 8'h00, 16'd17);

      // Mid-operation reset with P=4 and an active grant.
      mode = 1'b1;
      req  = 8'b0001_0000;
      tick(); chk_all("pre_rst0", 1'b1, 3'd4, 8'h10, 16'd17);
      tick(); chk_all("pre_rst1", 1'b1, 3'd4, 8'h10, 16'd18);
      reset = 1'b1;
      tick(); chk_all("mid_rst", 1'b0, 3'd0, 8'h00, 16'd0);
      chk("mid_rst.count4", 32'(grant_count4), 32'd0);
      reset     = 1'b0;
      gnt_ready = 1'b0;
      req       = 8'b0001_0001;
      tick(); chk_all("post_rst", 1'b1, 3'd4, 8'h10, 16'd0);
      gnt_ready = 1'b1;
      req       = 8'h00;
      tick(); chk_all("post_rst_acc", 1'b0, 3'd4, 8'h00, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
